multicycle_control: RTL and testbench

- Multi-cycle MIPS main control FSM. It sequences the shared datapath (single memory, IR, A/B, ALUOut registers) through fetch, decode, execute, memory and writeback.
- Supports add (R-type funct 0x20), addi, lw, sw, bgtz and j.
- Adds a memory ready handshake, parametrised ALU-control width and a retired-instruction counter.
- Sits between the IR opcode/funct fields and the datapath mux/enable inputs.

---
 rtl/multicycle_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM with memory handshake and instret
//
// Sequences a shared datapath through fetch/decode/execute/memory/writeback
// for add, addi, lw, sw, bgtz and j.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (unsupported instruction -> TRAP).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct       IR[31:26], IR[5:0]
//   mem_ready           memory completes the current request this cycle
//   alu_gtz             ALU flag: operand A > 0 (signed)
//   mem_req, mem_write  memory request / write qualifier
//   iord                address source (0 PC, 1 ALUOut)
//   ir_write, pc_write, pc_write_cond, pc_source
//   alu_src_a, alu_src_b, alu_ctrl
//   reg_dst, mem_to_reg, reg_write
//   instret             retired-instruction count
//   state               current state (debug)
//   illegal_op          TRAP indicator (only with MC_ILLEGAL_TRAP_EN)

module multicycle_control #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  input  logic                 alu_gtz,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic [CNT_W-1:0]     instret,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic                 illegal_op,
`endif
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;

  localparam logic [ALUCTRL_W-1:0] ALU_NOP = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_GTZ = ALUCTRL_W'(2);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              retire;
  logic              illegal;

  // alu_gtz is consumed by the datapath's PC-write gating, not by this FSM.
  logic              unused_gtz;
  assign unused_gtz = alu_gtz;

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    illegal       = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_NOP;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        // IR and PC only update on the cycle the memory returns the word.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_ADDI:      state_d = ADDIEX;
          OP_BGTZ:      state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_RTYPE:     state_d = (funct == FN_ADD) ? EXEC : FETCH;
          default:      state_d = FETCH;
        endcase
`ifdef MC_ILLEGAL_TRAP_EN
        if (state_d == FETCH) state_d = TRAP;
`endif
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        // IR is stable, so opcode still selects between lw and sw here.
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_ADD;
        state_d   = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_GTZ;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
`endif
      default: state_d = FETCH;
    endcase

    if (rst) begin
      illegal       = 1'b0;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctrl      = ALU_NOP;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
    end

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
  assign state   = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int ALUCTRL_W = 3;
  localparam int CNT_W     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 mem_ready;
  logic                 alu_gtz;
  logic                 mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]           pc_source, alu_src_b;
  logic                 alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic [CNT_W-1:0]     instret;
  logic [3:0]           state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic                 illegal_op;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUCTRL_W(ALUCTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .alu_gtz(alu_gtz),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instret(instret),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; mem_ready = 1'b1; alu_gtz = 1'b0;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst = 1'b0; #1;
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_alu_src_b", 32'(alu_src_b), 32'd1);
    check("fetch_alu_ctrl", 32'(alu_ctrl), 32'd1);
    check("fetch_ir_write", 32'(ir_write), 32'd1);

    // FETCH stall: no IR/PC update, state held
    mem_ready = 1'b0; #1;
    check("fetch_stall_ir", 32'(ir_write), 32'd0);
    check("fetch_stall_pc", 32'(pc_write), 32'd0);
    step();
    check("fetch_stall_state", 32'(state), 32'd0);
    mem_ready = 1'b1;

    // add then addi
    set_instr(6'h00, 6'h20);
    step(); check("add_s1", 32'(state), 32'd1);
    check("dec_alu_src_b", 32'(alu_src_b), 32'd3);
    step(); check("add_s6", 32'(state), 32'd6);
    check("exec_alu_src_a", 32'(alu_src_a), 32'd1);
    check("exec_alu_src_b", 32'(alu_src_b), 32'd0);
    step(); check("add_s7", 32'(state), 32'd7);
    check("rwb_reg_write", 32'(reg_write), 32'd1);
    check("rwb_reg_dst", 32'(reg_dst), 32'd1);
    step(); exp_cnt++;
    check("add_back_fetch", 32'(state), 32'd0);
    check("add_instret", 32'(instret), 32'(exp_cnt));
    set_instr(6'h08, 6'h00);
    step(); check("addi_s1", 32'(state), 32'd1);
    step(); check("addi_s8", 32'(state), 32'd8);
    check("addiex_alu_src_b", 32'(alu_src_b), 32'd2);
    step(); check("addi_s9", 32'(state), 32'd9);
    check("addiwb_reg_write", 32'(reg_write), 32'd1);
    check("addiwb_reg_dst", 32'(reg_dst), 32'd0);
    step(); exp_cnt++;
    check("addi_instret", 32'(instret), 32'(exp_cnt));

    // lw with two wait cycles in MEMRD
    set_instr(6'h23, 6'h00);
    step(); check("lw_s1", 32'(state), 32'd1);
    step(); check("lw_s2", 32'(state), 32'd2);
    step(); check("lw_s3a", 32'(state), 32'd3);
    mem_ready = 1'b0; #1;
    check("memrd_mem_req", 32'(mem_req), 32'd1);
    check("memrd_iord", 32'(iord), 32'd1);
    step(); check("lw_s3b", 32'(state), 32'd3);
    check("memrd_wait_req", 32'(mem_req), 32'd1);
    step(); check("lw_s3c", 32'(state), 32'd3);
    mem_ready = 1'b1; #1;
    check("memrd_last_iord", 32'(iord), 32'd1);
    step(); check("lw_s4", 32'(state), 32'd4);
    check("memwb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("memwb_reg_write", 32'(reg_write), 32'd1);
    step(); exp_cnt++;
    check("lw_back_fetch", 32'(state), 32'd0);
    check("lw_instret", 32'(instret), 32'(exp_cnt));

    // sw with one wait cycle, then bgtz
    set_instr(6'h2b, 6'h00);
    step(); check("sw_s1", 32'(state), 32'd1);
    step(); check("sw_s2", 32'(state), 32'd2);
    check("memadr_no_write", 32'(mem_write), 32'd0);
    step(); check("sw_s5", 32'(state), 32'd5);
    mem_ready = 1'b0; #1;
    check("memwr_wait_write", 32'(mem_write), 32'd1);
    check("memwr_iord", 32'(iord), 32'd1);
    step(); check("sw_s5_hold", 32'(state), 32'd5);
    check("sw_wait_instret", 32'(instret), 32'(exp_cnt));
    mem_ready = 1'b1; #1;
    check("memwr_write", 32'(mem_write), 32'd1);
    step(); exp_cnt++;
    check("sw_back_fetch", 32'(state), 32'd0);
    check("fetch_no_write", 32'(mem_write), 32'd0);
    check("sw_instret", 32'(instret), 32'(exp_cnt));
    set_instr(6'h07, 6'h00); alu_gtz = 1'b1;
    step(); step(); check("bgtz_s10", 32'(state), 32'd10);
    check("br_pc_write_cond", 32'(pc_write_cond), 32'd1);
    check("br_pc_source", 32'(pc_source), 32'd1);
    check("br_alu_ctrl", 32'(alu_ctrl), 32'd2);
    check("br_mem_write", 32'(mem_write), 32'd0);
    step(); exp_cnt++; alu_gtz = 1'b0;
    check("bgtz_instret", 32'(instret), 32'(exp_cnt));

    // j
    set_instr(6'h02, 6'h00);
    step(); step(); check("j_s11", 32'(state), 32'd11);
    check("j_pc_write", 32'(pc_write), 32'd1);
    check("j_pc_source", 32'(pc_source), 32'd2);
    step(); exp_cnt++;
    check("j_instret", 32'(instret), 32'(exp_cnt));

    // unsupported: opcode 0 funct 0x22
    set_instr(6'h00, 6'h22);
    step(); check("ill_s1", 32'(state), 32'd1);
    step();
`ifdef MC_ILLEGAL_TRAP_EN
    check("ill_trap", 32'(state), 32'd12);
    check("ill_flag", 32'(illegal_op), 32'd1);
    step(); step();
    check("ill_trap_hold", 32'(state), 32'd12);
    check("ill_mem_req", 32'(mem_req), 32'd0);
    check("ill_instret", 32'(instret), 32'(exp_cnt));
    rst = 1'b1; step(); rst = 1'b0; exp_cnt = 0; #1;
    check("ill_rst_state", 32'(state), 32'd0);
    check("ill_rst_flag", 32'(illegal_op), 32'd0);
`else
    check("ill_nop_fetch", 32'(state), 32'd0);
    check("ill_instret", 32'(instret), 32'(exp_cnt));
`endif

    // Run jumps up to all-ones, then one more wraps to zero.
    set_instr(6'h02, 6'h00);
    while (exp_cnt != 15) begin
      step(); step(); step(); exp_cnt++;
    end
    check("cnt_all_ones", 32'(instret), 32'd15);
    step(); step(); step();
    check("cnt_wrap", 32'(instret), 32'd0);

    // Reset during MEMRD
    set_instr(6'h23, 6'h00);
    step(); step(); step();
    check("mid_s3", 32'(state), 32'd3);
    mem_ready = 1'b0; rst = 1'b1; #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_iord", 32'(iord), 32'd0);
    step();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_instret", 32'(instret), 32'd0);
    mem_ready = 1'b1; #1;
    check("mid_rst_ir_write", 32'(ir_write), 32'd0);
    check("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst = 1'b0; #1;
    check("post_rst_mem_req", 32'(mem_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
